// File: rtl/bus_pkg.sv
// Shared types and constants for 8088 demultiplexed-bus targets.
// Latency: n/a (types only).
// Backpressure: n/a. Targets stretch a bus cycle by pulling READY low.
package bus_pkg;

    // Bus-cycle sequencing of one target.
    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        WAIT,
        ACTIVE
    } state_e;

    // Direction of the access latched when the strobe arrives.
    typedef enum logic {
        ACC_READ,
        ACC_WRITE
    } acc_e;

    // Values of IOM selecting each address space.
    localparam logic MEM_SPACE = 1'b0;
    localparam logic IO_SPACE  = 1'b1;

    // Shared counter for the strobe timeout and the wait states.
    localparam int CNT_W = 8;

endpackage

// File: rtl/bus_target_ram.sv
// Storage array of one bus target; contents are not reset.
// Latency: read is combinational from addr_i; a write lands on the CLK edge with we_i=1.
// Backpressure: none, every write is accepted.
// Ports: clk_i clock | we_i write enable | addr_i word address | wdat_i write data | rdat_o read data
module bus_target_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdat_i,
    output logic [DATA_W-1:0] rdat_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdat_i;
        end
    end

    assign rdat_o = mem_q[addr_i];

endmodule

// File: rtl/bus_target.sv
// Memory or I/O target on the demultiplexed 8088 bus with a decoded address window and wait states.
// Latency: HIT 1 cycle after ALE; read data 1 cycle after RD sampled low plus WAIT_STATES cycles.
// Backpressure: READY is held low for WAIT_STATES cycles per access; the system ANDs all targets.
// Ports: CLK, RESET_N (async, active low) | ALE, IOM, RD, WR, Address bus controls |
//        Data tri-state data bus | READY wait request | HIT registered decode indicator
module bus_target
    import bus_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 20,
    parameter int IS_IO          = 0,
    parameter int BASE           = 0,
    parameter int DEPTH          = 256,
    parameter int WAIT_STATES    = 0,
    parameter int STROBE_TIMEOUT = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ALE,
    input  logic              IOM,
    input  logic              RD,
    input  logic              WR,
    input  logic [ADDR_W-1:0] Address,
    inout  wire  [DATA_W-1:0] Data,
    output logic              READY,
    output logic              HIT
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic            SPACE   = (IS_IO != 0) ? IO_SPACE : MEM_SPACE;
    localparam logic [ADDR_W:0] BASE_X  = (ADDR_W+1)'(BASE);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(STROBE_TIMEOUT);
    localparam logic [CNT_W-1:0] WS     = CNT_W'(WAIT_STATES);

    state_e              state_q, state_d;
    acc_e                acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]       off_q, off_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic                ready_q, hit_q, oe_q;
    logic                ram_we;
    logic [DATA_W-1:0]   rdat;
    logic [ADDR_W:0]     rel;
    logic                addr_hit;

    // Addresses below BASE wrap to a large value in the extra top bit, so a
    // single unsigned compare rejects both sides of the window.
    assign rel      = {1'b0, Address} - BASE_X;
    assign addr_hit = (IOM == SPACE) && (rel < DEPTH_X);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        wdat_d  = wdat_q;
        ram_we  = 1'b0;

        // Track the bus while WR is low; the last sample is what gets committed.
        if (state_q != IDLE && !WR) begin
            wdat_d = Data;
        end

        // A new address phase always restarts the decode, abandoning any
        // access in flight without committing it.
        if (ALE) begin
            if (addr_hit) begin
                state_d = DECODE;
                cnt_d   = TMO;
                off_d   = rel[AW-1:0];
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                DECODE: begin
                    if (!RD && !WR) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (!RD || !WR) begin
                        acc_d = RD ? ACC_WRITE : ACC_READ;
                        if (WAIT_STATES > 0) begin
                            state_d = WAIT;
                            cnt_d   = WS;
                        end else begin
                            state_d = ACTIVE;
                            cnt_d   = '0;
                        end
                    end else if (cnt_q <= 1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q <= 1) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ACTIVE: begin
                    if (acc_q == ACC_READ) begin
                        if (RD) begin
                            state_d = IDLE;
                        end
                    end else if (WR) begin
                        ram_we  = 1'b1;
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            acc_q   <= ACC_READ;
            cnt_q   <= '0;
            off_q   <= '0;
            wdat_q  <= '0;
            ready_q <= 1'b1;
            hit_q   <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            wdat_q  <= wdat_d;
            // Outputs follow the next state so they change on the same edge.
            ready_q <= (state_d != WAIT);
            hit_q   <= (state_d != IDLE);
            oe_q    <= (state_d == ACTIVE) && (acc_d == ACC_READ);
        end
    end

    bus_target_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk_i  (CLK),
        .we_i   (ram_we),
        .addr_i (off_q),
        .wdat_i (wdat_q),
        .rdat_o (rdat)
    );

    assign Data  = oe_q ? rdat : {DATA_W{1'bz}};
    assign READY = ready_q;
    assign HIT   = hit_q;

endmodule

// File: tb/tb_bus_target.sv
module tb_bus_target;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ale, iom, rd_n, wr_n;
    logic [19:0] addr;
    logic [7:0]  drv_dat;
    logic        drv_en;
    wire  [7:0]  data_bus;
    logic        ready_a, ready_b, ready_c;
    logic        hit_a, hit_b, hit_c;
    logic        ready;
    logic [2:0]  hits;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    // Released bus reads back as all ones.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (data_bus[g]);
    end

    assign data_bus = drv_en ? drv_dat : 8'hzz;
    assign ready    = ready_a & ready_b & ready_c;
    assign hits     = {hit_c, hit_b, hit_a};

    bus_target #(.IS_IO(0), .BASE('h400), .DEPTH(256), .WAIT_STATES(0)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .ALE(ale), .IOM(iom), .RD(rd_n), .WR(wr_n),
        .Address(addr), .Data(data_bus), .READY(ready_a), .HIT(hit_a));

    bus_target #(.IS_IO(1), .BASE('h60), .DEPTH(16), .WAIT_STATES(0)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .ALE(ale), .IOM(iom), .RD(rd_n), .WR(wr_n),
        .Address(addr), .Data(data_bus), .READY(ready_b), .HIT(hit_b));

    bus_target #(.IS_IO(0), .BASE('h800), .DEPTH(256), .WAIT_STATES(3)) dut_c (
        .CLK(clk), .RESET_N(rst_n), .ALE(ale), .IOM(iom), .RD(rd_n), .WR(wr_n),
        .Address(addr), .Data(data_bus), .READY(ready_c), .HIT(hit_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input string tag, input logic [19:0] a, input logic io,
                            input logic [2:0] exp_hits, input logic [7:0] exp_dat, input int exp_ws);
        int lows;
        logic [7:0] want;
        exp_q.push_back(exp_dat);
        @(negedge clk); ale = 1'b1; addr = a; iom = io;
        @(negedge clk); ale = 1'b0; rd_n = 1'b0;
        check({tag, " hit"}, 32'(hits), 32'(exp_hits));
        lows = 0;
        @(negedge clk);
        while (ready !== 1'b1 && lows < 20) begin
            lows++;
            @(negedge clk);
        end
        want = exp_q.pop_front();
        check({tag, " wait"}, 32'(lows), 32'(exp_ws));
        check({tag, " data"}, 32'(data_bus), 32'(want));
        rd_n = 1'b1;
        @(negedge clk);
        check({tag, " release"}, 32'({hits, data_bus}), 32'({3'b000, 8'hFF}));
    endtask

    task automatic bus_write(input string tag, input logic [19:0] a, input logic io,
                             input logic [7:0] d, input int exp_ws);
        int lows;
        @(negedge clk); ale = 1'b1; addr = a; iom = io;
        @(negedge clk); ale = 1'b0; wr_n = 1'b0; drv_dat = d; drv_en = 1'b1;
        lows = 0;
        @(negedge clk);
        while (ready !== 1'b1 && lows < 20) begin
            lows++;
            @(negedge clk);
        end
        check({tag, " wait"}, 32'(lows), 32'(exp_ws));
        wr_n = 1'b1; drv_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ale = 1'b0; iom = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
        addr = '0; drv_dat = '0; drv_en = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ready", 32'(ready), 32'(1));
        check("reset hit", 32'(hits), 32'(0));
        check("reset data", 32'(data_bus), 32'hFF);
        rst_n = 1'b1;

        // Zero-wait memory target.
        bus_write("mem wr 410", 20'h00410, 1'b0, 8'hA5, 0);
        bus_read ("mem rd 410", 20'h00410, 1'b0, 3'b001, 8'hA5, 0);
        bus_read ("io-space rd 410", 20'h00410, 1'b1, 3'b000, 8'hFF, 0);

        // I/O target and the memory-space alias of its address.
        bus_write("io wr 62", 20'h00062, 1'b1, 8'h3C, 0);
        bus_read ("io rd 62", 20'h00062, 1'b1, 3'b010, 8'h3C, 0);
        bus_read ("mem rd 62", 20'h00062, 1'b0, 3'b000, 8'hFF, 0);

        // Three wait states.
        bus_write("ws3 wr 810", 20'h00810, 1'b0, 8'h77, 3);
        bus_read ("ws3 rd 810", 20'h00810, 1'b0, 3'b100, 8'h77, 3);

        // Window edges.
        bus_read ("edge 3FF", 20'h003FF, 1'b0, 3'b000, 8'hFF, 0);
        bus_read ("edge 500", 20'h00500, 1'b0, 3'b000, 8'hFF, 0);
        bus_write("edge wr 4FF", 20'h004FF, 1'b0, 8'h5A, 0);
        bus_read ("edge rd 4FF", 20'h004FF, 1'b0, 3'b001, 8'h5A, 0);
        check("edge word FF", 32'(dut_a.u_ram.mem_q[255]), 32'h5A);

        // Decode with no strobe times out after four cycles.
        @(negedge clk); ale = 1'b1; addr = 20'h00410; iom = 1'b0;
        @(negedge clk); ale = 1'b0;
        repeat (3) @(negedge clk);
        check("timeout still hit", 32'(hits), 32'(3'b001));
        @(negedge clk);
        check("timeout dropped", 32'(hits), 32'(0));
        bus_read ("after timeout", 20'h00410, 1'b0, 3'b001, 8'hA5, 0);

        // RD and WR low together: no access.
        @(negedge clk); ale = 1'b1; addr = 20'h00410; iom = 1'b0;
        @(negedge clk); ale = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        check("both strobes", 32'({hits, data_bus}), 32'({3'b000, 8'hFF}));
        rd_n = 1'b1; wr_n = 1'b1;
        bus_read ("after both", 20'h00410, 1'b0, 3'b001, 8'hA5, 0);

        // Reset in the middle of a wait-stated write.
        bus_write("pre wr 805", 20'h00805, 1'b0, 8'h11, 3);
        bus_read ("pre rd 805", 20'h00805, 1'b0, 3'b100, 8'h11, 3);
        @(negedge clk); ale = 1'b1; addr = 20'h00805; iom = 1'b0;
        @(negedge clk); ale = 1'b0; wr_n = 1'b0; drv_dat = 8'h99; drv_en = 1'b1;
        @(negedge clk);
        check("mid-write ready low", 32'(ready), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        check("async reset ready", 32'(ready), 32'(1));
        check("async reset hit", 32'(hits), 32'(0));
        drv_en = 1'b0; wr_n = 1'b1;
        #1;
        check("async reset data", 32'(data_bus), 32'hFF);
        @(negedge clk); rst_n = 1'b1;
        bus_read ("post reset 805", 20'h00805, 1'b0, 3'b100, 8'h11, 3);
        bus_read ("post reset 410", 20'h00410, 1'b0, 3'b001, 8'hA5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
